program_memory_loader: RTL

- Parametrised, writable successor to the fixed instruction ROM. It is a synchronous instruction memory with registered read.
- After reset it fills every entry with DEFAULT_WORD. At runtime a byte-serial loader port can replace the program.
- It sits between the CPU fetch stage and the board-level loader (UART/keyboard bridge).
- oCpuHold tells the CPU to stall its PC while the memory is being cleared or loaded.

---
 rtl/program_memory_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/program_memory_loader.sv
// Writable instruction memory with registered read. After reset it fills itself with
// DEFAULT_WORD, and a byte-serial loader port can then replace the program at runtime.
module program_memory_loader #(
    parameter int                    DATA_WIDTH   = 30,
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oCpuHold,
    input  logic                  iLoadStart,
    input  logic [7:0]            iLoadByte,
    input  logic                  iLoadValid,
    input  logic                  iLoadLast,
    output logic                  oLoadReady,
    output logic                  oLoadError,
    output logic [ADDR_WIDTH:0]   oWordCount
);
    localparam int BPW   = (DATA_WIDTH + 7) / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BIW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [BIW-1:0]        LAST_LANE = BIW'(BPW - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic [BIW-1:0]        bidx_q, bidx_d;
    logic [BPW*8-1:0]      asm_q, asm_d;
    logic                  err_q, err_d;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        wcnt_d  = wcnt_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = clr_q;
        wdata   = DEFAULT_WORD;
        case (state_q)
            S_CLEAR: begin
                we    = 1'b1;
                clr_d = clr_q + 1'b1;
                if (clr_q == LAST_ADDR) state_d = S_RUN;
            end
            S_RUN: begin
                if (iLoadStart) begin
                    wcnt_d  = '0;
                    bidx_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // a start pulse wins over a byte presented on the same edge
                if (iLoadStart) begin
                    wcnt_d = '0;
                    bidx_d = '0;
                    err_d  = 1'b0;
                end else if (iLoadValid) begin
                    asm_d[{bidx_q, 3'b000} +: 8] = iLoadByte;
                    if (bidx_q == LAST_LANE) begin
                        bidx_d = '0;
                        // pointer stops at DEPTH, so the count saturates and extra words are dropped
                        if (wcnt_q < DEPTH_C) begin
                            we     = 1'b1;
                            waddr  = wcnt_q[ADDR_WIDTH-1:0];
                            wdata  = asm_d[DATA_WIDTH-1:0];
                            wcnt_d = wcnt_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                    if (iLoadLast) begin
                        state_d = S_RUN;
                        bidx_d  = '0;
                        if (bidx_q != LAST_LANE) err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_CLEAR;
            clr_q        <= '0;
            wcnt_q       <= '0;
            bidx_q       <= '0;
            asm_q        <= '0;
            err_q        <= 1'b0;
            oInstruction <= DEFAULT_WORD;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            wcnt_q  <= wcnt_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            if (state_q == S_RUN && 32'(iAddress) < DEPTH)
                oInstruction <= mem[iAddress[ADDR_WIDTH-1:0]];
            else
                oInstruction <= DEFAULT_WORD;
        end
    end

    always_ff @(posedge Clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign oCpuHold   = (state_q != S_RUN);
    assign oLoadReady = (state_q == S_LOAD);
    assign oLoadError = err_q;
    assign oWordCount = wcnt_q;
endmodule
